// File: rtl/stepper_seq_ctrl.sv
// stepper_seq_ctrl: 4-coil unipolar stepper sequencer with wave/full/half
// modes, programmable step period, step-count jobs, abort and a signed
// position counter.
// Optional feature macro: HOLD_TORQUE_EN (keep last coil pattern in IDLE).
module stepper_seq_ctrl #(
    parameter int unsigned PERIOD_W = 16,
    parameter int unsigned STEPS_W  = 16,
    parameter int unsigned POS_W    = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic                i_abort,
    input  logic                i_dir,
    input  logic [1:0]          i_mode,
    input  logic [STEPS_W-1:0]  i_steps,
    input  logic [PERIOD_W-1:0] i_period,
    output logic [3:0]          o_coils,
    output logic                o_busy,
    output logic                o_done,
    output logic [POS_W-1:0]    o_pos
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [1:0] MODE_WAVE = 2'b00;
    localparam logic [1:0] MODE_HALF = 2'b10;

`ifdef HOLD_TORQUE_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    // Half-step phase table; even entries are single-coil, odd are two-coil.
    function automatic logic [3:0] phase(input logic [2:0] idx);
        logic [3:0] pat;
        case (idx)
            3'd0:    pat = 4'b1000;
            3'd1:    pat = 4'b1100;
            3'd2:    pat = 4'b0100;
            3'd3:    pat = 4'b0110;
            3'd4:    pat = 4'b0010;
            3'd5:    pat = 4'b0011;
            3'd6:    pat = 4'b0001;
            default: pat = 4'b1001;
        endcase
        return pat;
    endfunction

    state_t              r_state, w_state;
    logic [2:0]          r_idx, w_idx;
    logic [3:0]          r_coils, w_coils;
    logic                r_busy, w_busy;
    logic                r_done, w_done;
    logic [POS_W-1:0]    r_pos, w_pos;
    logic [STEPS_W-1:0]  r_remain, w_remain;
    logic [PERIOD_W-1:0] r_cnt, w_cnt;
    logic [PERIOD_W-1:0] r_reload, w_reload;
    logic                r_dir, w_dir;
    logic                r_half, w_half;

    logic [2:0]          w_idx_align;
    logic [2:0]          w_idx_inc;
    logic [2:0]          w_idx_step;
    logic [PERIOD_W-1:0] w_per_eff;
    logic [3:0]          w_idle_coils;

    // Start-time helpers: phase alignment and zero-period substitution.
    always_comb begin
        w_idx_align = r_idx;
        if (i_mode == MODE_WAVE) begin
            w_idx_align = {r_idx[2:1], 1'b0};
        end else if (i_mode != MODE_HALF) begin
            w_idx_align = {r_idx[2:1], 1'b1};
        end
        w_per_eff    = (i_period == '0) ? PERIOD_W'(1) : i_period;
        w_idx_inc    = r_half ? 3'd1 : 3'd2;
        w_idx_step   = r_dir ? (r_idx + w_idx_inc) : (r_idx - w_idx_inc);
        w_idle_coils = HOLD ? r_coils : 4'b0000;
    end

    // Next-state and registered-output logic.
    always_comb begin
        w_state  = r_state;
        w_idx    = r_idx;
        w_coils  = r_coils;
        w_busy   = r_busy;
        w_done   = 1'b0;
        w_pos    = r_pos;
        w_remain = r_remain;
        w_cnt    = r_cnt;
        w_reload = r_reload;
        w_dir    = r_dir;
        w_half   = r_half;

        case (r_state)
            S_IDLE: begin
                w_coils = w_idle_coils;
                if (i_start && (i_steps != '0)) begin
                    w_state  = S_RUN;
                    w_busy   = 1'b1;
                    w_dir    = i_dir;
                    w_half   = (i_mode == MODE_HALF);
                    w_idx    = w_idx_align;
                    w_coils  = phase(w_idx_align);
                    w_remain = i_steps;
                    w_reload = w_per_eff - PERIOD_W'(1);
                    w_cnt    = w_per_eff - PERIOD_W'(1);
                end
            end
            default: begin
                if (i_abort) begin
                    w_state = S_IDLE;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                    w_coils = w_idle_coils;
                end else if (r_cnt == '0) begin
                    w_idx    = w_idx_step;
                    w_coils  = phase(w_idx_step);
                    w_pos    = r_dir ? (r_pos + POS_W'(1)) : (r_pos - POS_W'(1));
                    w_remain = r_remain - STEPS_W'(1);
                    w_cnt    = r_reload;
                    if (r_remain == STEPS_W'(1)) begin
                        w_state = S_IDLE;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                        if (!HOLD) begin
                            w_coils = 4'b0000;
                        end
                    end
                end else begin
                    w_cnt = r_cnt - PERIOD_W'(1);
                end
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_idx    <= 3'd0;
            r_coils  <= 4'b0000;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pos    <= '0;
            r_remain <= '0;
            r_cnt    <= '0;
            r_reload <= '0;
            r_dir    <= 1'b0;
            r_half   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_idx    <= w_idx;
            r_coils  <= w_coils;
            r_busy   <= w_busy;
            r_done   <= w_done;
            r_pos    <= w_pos;
            r_remain <= w_remain;
            r_cnt    <= w_cnt;
            r_reload <= w_reload;
            r_dir    <= w_dir;
            r_half   <= w_half;
        end
    end

    assign o_coils = r_coils;
    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_pos   = r_pos;

endmodule

// File: tb/tb_stepper_seq_ctrl.sv
// tb_stepper_seq_ctrl: directed plus randomized jobs checked against an
// elapsed-time reference model of the stepper sequencer.
module tb_stepper_seq_ctrl;

`ifdef HOLD_TORQUE_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic        i_dir = 1'b0;
    logic [1:0]  i_mode = 2'b00;
    logic [15:0] i_steps = '0;
    logic [15:0] i_period = '0;
    logic [3:0]  o_coils;
    logic        o_busy;
    logic        o_done;
    logic [23:0] o_pos;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [3:0]  tbl [8];
    int          m_idx = 0;
    logic [23:0] m_pos = '0;
    logic [3:0]  m_coils = '0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    int          m_elapsed = 0;
    int          m_p = 1;
    int          m_n = 0;
    int          m_delta = 0;
    logic        m_dir = 1'b0;

    stepper_seq_ctrl #(.PERIOD_W(16), .STEPS_W(16), .POS_W(24)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
        .i_dir(i_dir), .i_mode(i_mode), .i_steps(i_steps), .i_period(i_period),
        .o_coils(o_coils), .o_busy(o_busy), .o_done(o_done), .o_pos(o_pos)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: step k of a job lands when elapsed cycles reach k*P.
    task automatic model_edge(input logic r, input logic st, input logic ab,
                              input logic d, input logic [1:0] md,
                              input logic [15:0] n, input logic [15:0] p);
        if (r) begin
            m_idx = 0; m_pos = '0; m_coils = '0; m_busy = 0; m_done = 0;
        end else if (!m_busy) begin
            m_done = 0;
            if (st && n != 0) begin
                if (md == 2'b00)      m_idx = m_idx & 6;
                else if (md != 2'b10) m_idx = m_idx | 1;
                m_busy = 1; m_elapsed = 0; m_n = int'(n);
                m_p = (p == 0) ? 1 : int'(p);
                m_dir = d;
                m_delta = ((md == 2'b10) ? 1 : 2) * (d ? 1 : -1);
                m_coils = tbl[m_idx];
            end else begin
                m_coils = HOLD ? m_coils : 4'b0000;
            end
        end else begin
            m_elapsed++;
            m_done = 0;
            if (ab) begin
                m_busy = 0; m_done = 1;
                m_coils = HOLD ? m_coils : 4'b0000;
            end else if (m_elapsed % m_p == 0) begin
                m_idx = (m_idx + m_delta + 8) % 8;
                m_pos = m_dir ? m_pos + 24'd1 : m_pos - 24'd1;
                m_coils = tbl[m_idx];
                if (m_elapsed / m_p == m_n) begin
                    m_busy = 0; m_done = 1;
                    m_coils = HOLD ? m_coils : 4'b0000;
                end
            end
        end
    endtask

    task automatic tick(input logic r, input logic st, input logic ab,
                        input logic d, input logic [1:0] md,
                        input logic [15:0] n, input logic [15:0] p);
        rst = r; i_start = st; i_abort = ab; i_dir = d; i_mode = md;
        i_steps = n; i_period = p;
        @(posedge clk);
        #1;
        model_edge(r, st, ab, d, md, n, p);
        check("coils", 32'(o_coils), 32'(m_coils));
        check("busy", 32'(o_busy), 32'(m_busy));
        check("done", 32'(o_done), 32'(m_done));
        check("pos", 32'(o_pos), 32'(m_pos));
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) tick(0, 0, 0, 0, 2'b00, 16'd0, 16'd0);
    endtask

    task automatic do_reset();
        tick(1, 0, 0, 0, 2'b00, 16'd0, 16'd0);
        tick(1, 0, 0, 0, 2'b00, 16'd0, 16'd0);
    endtask

    initial begin
        tbl[0] = 4'b1000; tbl[1] = 4'b1100; tbl[2] = 4'b0100; tbl[3] = 4'b0110;
        tbl[4] = 4'b0010; tbl[5] = 4'b0011; tbl[6] = 4'b0001; tbl[7] = 4'b1001;

        // Reset state
        do_reset();
        check("rst_coils", 32'(o_coils), 32'd0);
        check("rst_pos", 32'(o_pos), 32'd0);

        // Half mode, forward, 4 steps, period 3
        tick(0, 1, 0, 1, 2'b10, 16'd4, 16'd3);
        check("half_t0", 32'(o_coils), 32'b1000);
        idle(3);
        check("half_t3", 32'(o_coils), 32'b1100);
        idle(6);
        check("half_t9", 32'(o_coils), 32'b0110);
        idle(2);
        check("half_t11_nodone", 32'(o_done), 32'd0);
        idle(1);
        check("half_t12_done", 32'(o_done), 32'd1);
        check("half_t12_coils", 32'(o_coils), HOLD ? 32'b0010 : 32'b0000);
        check("half_pos", 32'(o_pos), 32'd4);
        idle(1);
        check("half_done_pulse", 32'(o_done), 32'd0);

        // Wave mode, reverse, 3 steps, period 1, from idx 0
        do_reset();
        tick(0, 1, 0, 0, 2'b00, 16'd3, 16'd1);
        check("wave_t0", 32'(o_coils), 32'b1000);
        idle(1);
        check("wave_t1", 32'(o_coils), 32'b0001);
        idle(1);
        check("wave_t2", 32'(o_coils), 32'b0010);
        idle(1);
        check("wave_pos", 32'(o_pos), 32'hFFFFFD);
        idle(2);

        // Full mode, 2 steps, period 0 behaves as 1
        do_reset();
        tick(0, 1, 0, 1, 2'b01, 16'd2, 16'd0);
        check("full_t0", 32'(o_coils), 32'b1100);
        idle(1);
        check("full_t1", 32'(o_coils), 32'b0110);
        check("full_t1_busy", 32'(o_busy), 32'd1);
        idle(1);
        check("full_t2_busy", 32'(o_busy), 32'd0);
        idle(2);

        // Job ending on 0110 then idle coil hold behaviour
        do_reset();
        tick(0, 1, 0, 1, 2'b10, 16'd3, 16'd1);
        idle(5);
        check("hold_idle", 32'(o_coils), HOLD ? 32'b0110 : 32'b0000);

        // Abort sampled at t+6 coincides with step 3 edge
        do_reset();
        tick(0, 1, 0, 1, 2'b01, 16'd10, 16'd2);
        idle(5);
        tick(0, 0, 1, 0, 2'b00, 16'd0, 16'd0);
        check("abort_done", 32'(o_done), 32'd1);
        check("abort_busy", 32'(o_busy), 32'd0);
        check("abort_pos", 32'(o_pos), 32'd2);
        idle(3);
        check("abort_pos_held", 32'(o_pos), 32'd2);
        tick(0, 0, 1, 0, 2'b00, 16'd0, 16'd0);

        // Reset mid-job, then a zero-step start
        tick(0, 1, 0, 0, 2'b10, 16'd8, 16'd1);
        idle(3);
        tick(1, 0, 0, 0, 2'b00, 16'd0, 16'd0);
        check("midrst_coils", 32'(o_coils), 32'd0);
        check("midrst_busy", 32'(o_busy), 32'd0);
        check("midrst_pos", 32'(o_pos), 32'd0);
        tick(0, 1, 0, 1, 2'b10, 16'd0, 16'd5);
        idle(2);
        check("zero_steps_busy", 32'(o_busy), 32'd0);
        check("zero_steps_done", 32'(o_done), 32'd0);

        // Randomized jobs with random aborts and stray starts
        for (int j = 0; j < 25; j++) begin
            logic [1:0]  md;
            logic        d;
            logic [15:0] n, p;
            md = 2'($urandom_range(0, 3));
            d  = 1'($urandom_range(0, 1));
            n  = 16'($urandom_range(0, 6));
            p  = 16'($urandom_range(0, 4));
            tick(0, 1, 0, d, md, n, p);
            for (int c = 0; c < 200 && m_busy; c++) begin
                tick(0, ($urandom_range(0, 7) == 0), ($urandom_range(0, 19) == 0),
                     1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                     16'($urandom_range(1, 6)), 16'($urandom_range(0, 4)));
            end
            tick(0, 0, ($urandom_range(0, 1) == 1), 0, 2'b00, 16'd0, 16'd0);
            idle(int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stepper_seq_ctrl.md
Name: stepper_seq_ctrl

Overview:
- Parametrised 4-coil unipolar stepper sequencer; successor to the fixed one-step-per-clock stepper FSM.
- Adds wave, full-step and half-step modes, a programmable step period, and a step-count job with start/busy/done handshake.
- Adds abort and a signed position counter.
- Sits between the motion-control register block and the coil driver pins.

Parameters:
- PERIOD_W, 16, width of step-period input (clock cycles per step).
- STEPS_W, 16, width of step-count input.
- POS_W, 24, width of signed position counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- i_start  in  1  one-cycle request to begin a job; sampled only in IDLE
- i_abort  in  1  stop current job at next edge
- i_dir  in  1  1 = forward (+), 0 = reverse (−); latched at start
- i_mode  in  2  00 wave, 01 full, 10 half, 11 reserved (treated as full); latched at start
- i_steps  in  STEPS_W  number of steps in job; latched at start
- i_period  in  PERIOD_W  clocks per step; latched at start
- o_coils  out  4  coil drive pattern, registered
- o_busy  out  1  job in progress
- o_done  out  1  one-cycle pulse at job end (normal or abort)
- o_pos  out  POS_W  signed accumulated step position, two's complement

Behaviour:
- Reset state (rst=1 at any edge, including mid-job):
  - state=IDLE, phase index idx=0, o_coils=0000, o_busy=0, o_done=0, o_pos=0.
  - Remaining count and period counter cleared.
- Phase table, idx 0..7: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001.
  - Wave mode uses even idx only; full mode uses odd idx only; half mode uses all.
- FSM has two states: IDLE and RUN.
- IDLE → RUN: i_start=1 and i_steps≠0 at edge t.
  - Latch dir, mode, steps and period; i_period=0 is treated as 1.
  - Align idx: wave clears idx[0]; full sets idx[0]; half leaves idx unchanged.
  - At edge t: o_busy=1; o_coils=table[aligned idx]; period counter loaded with P−1.
- i_start=1 with i_steps=0: ignored; no busy, no done.
- i_start is ignored while RUN.
- In RUN, the period counter decrements each clock. On reaching 0 it generates a step:
  - idx changes by ±1 in half mode and ±2 otherwise, modulo 8 wrap (7→0 forward, 0→7 reverse).
  - o_coils=table[new idx].
  - o_pos changes by ±1 per step in every mode, wrapping at POS_W.
  - Remaining count decrements; period counter reloads P−1.
  - Step k lands at edge t+k·P.
- Last step, remaining 1→0: at that same edge, state→IDLE, o_busy=0, o_done=1 for exactly one cycle.
- i_abort=1 in RUN:
  - Next edge: state→IDLE, o_busy=0, o_done=1; no further step.
  - If abort coincides with a step edge, abort wins and that step is not taken.
  - o_pos keeps the steps already taken.
- i_abort in IDLE: no effect.
- IDLE coil output is set by the optional feature.
- idx is retained across jobs, so consecutive jobs continue the sequence without a phase jump.

Optional Feature:
- Macro HOLD_TORQUE_EN.
- Defined: in IDLE, o_coils keeps the last pattern driven (holding torque). After reset it is 0000 until the first job.
- Not defined: o_coils=0000 on every IDLE cycle, including the cycle o_done is high. idx is still retained.

Test Plan:
- Reset, then half mode, dir=1, steps=4, period=3, start at t:
  - o_coils 1000 @t, 1100 @t+3, 0100 @t+6, 0110 @t+9, 0010 @t+12.
  - o_done=1 @t+12 only; o_pos=4.
- Wave mode, dir=0, steps=3, period=1, from idx=0:
  - o_coils sequence 1000, 0001, 0010, 0100, one step per clock.
  - idx wraps 0→6; o_pos=−3.
- Full mode, steps=2, period=0:
  - Behaves as period=1; alignment gives 1100 at start, then 0110, 0011.
  - Busy for exactly 2 cycles.
- Abort on cycle t+5 of a steps=10, period=2 job:
  - o_done @t+6, o_busy=0 @t+6.
  - o_pos=2, unless abort lands on the step edge at t+6 (then still 2; step 3 is suppressed).
- rst asserted mid-job:
  - All outputs zero next edge; a later start with steps=0 produces no busy and no done.
- Build with and without HOLD_TORQUE_EN:
  - After a job ending on 0110, IDLE o_coils is 0110 (defined) or 0000 (undefined).
